// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchroniser and counter debouncer for WIDTH
// slide switches and one push-button, with registered edge pulses.
//
// Ports:
//   clock        system clock
//   rst          asynchronous active-low reset
//   sw_in        raw bouncy slide switches (asynchronous)
//   btn_in       raw bouncy push-button, 1 = pressed (asynchronous)
//   sw_out       debounced switch levels
//   btn_level    debounced button level
//   btn_press    1-cycle pulse when btn_level rises
//   btn_release  1-cycle pulse when btn_level falls
//   sw_changed   1-cycle pulse when any sw_out bit updates
module sw_debounce #(
  parameter int          WIDTH           = 4,
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1000000
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             btn_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             btn_level,
  output logic             btn_press,
  output logic             btn_release,
  output logic             sw_changed
);

  // Bit WIDTH carries the button; bits WIDTH-1:0 the switches.
  localparam int          N    = WIDTH + 1;
  localparam logic [31:0] LAST = DEBOUNCE_CYCLES - 32'd1;

  logic [N-1:0] meta;
  logic [N-1:0] sync;
  logic [N-1:0] stable;
  logic [N-1:0] accept;
  logic [31:0]  cnt [N];

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= {btn_in, sw_in};
      sync <= meta;
    end
  end

  // A bit is accepted once it has disagreed with its stable value
  // for DEBOUNCE_CYCLES consecutive clocks.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N; i++) begin
      accept[i] = (sync[i] != stable[i]) && (cnt[i] == LAST);
    end
  end

  // Any agreement with the stable value wipes the run; no partial credit.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync[i] == stable[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 32'd1;
        end
      end
    end
  end

  // Pulses are registered alongside stable so they coincide with the
  // new level becoming visible.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      stable      <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      sw_changed  <= 1'b0;
    end else begin
      stable      <= stable ^ accept;
      btn_press   <= accept[WIDTH] & ~stable[WIDTH];
      btn_release <= accept[WIDTH] & stable[WIDTH];
      sw_changed  <= |accept[WIDTH-1:0];
    end
  end

  assign sw_out    = stable[WIDTH-1:0];
  assign btn_level = stable[WIDTH];

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed test of sw_debounce with DEBOUNCE_CYCLES=4,
// checked per cycle against a sample-window model plus literal checks.
module tb_sw_debounce;

  localparam int W = 4;
  localparam int D = 4;
  localparam int N = W + 1;

  logic         clock = 1'b0;
  logic         rst;
  logic [W-1:0] sw_in;
  logic         btn_in;
  logic [W-1:0] sw_out;
  logic         btn_level;
  logic         btn_press;
  logic         btn_release;
  logic         sw_changed;

  int n_chk  = 0;
  int n_fail = 0;

  sw_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(32'd4)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .sw_in      (sw_in),
    .btn_in     (btn_in),
    .sw_out     (sw_out),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .sw_changed (sw_changed)
  );

  always #5 clock = ~clock;

  // Model: a level is accepted when the D most recent synchronised
  // samples (raw samples from 2..D+1 edges ago) all hold the opposite value.
  logic [N-1:0] hist [$];
  logic [N-1:0] m_stable;
  logic         m_press, m_release, m_changed;

  always @(posedge clock or negedge rst) begin
    logic [N-1:0] nxt;
    if (!rst) begin
      hist.delete();
      for (int i = 0; i < D + 2; i++) hist.push_back('0);
      m_stable  <= '0;
      m_press   <= 1'b0;
      m_release <= 1'b0;
      m_changed <= 1'b0;
    end else begin
      nxt = m_stable;
      for (int b = 0; b < N; b++) begin
        int agree;
        agree = 0;
        for (int i = 0; i < D; i++)
          if (hist[hist.size() - 2 - i][b] != m_stable[b]) agree++;
        if (agree == D) nxt[b] = ~m_stable[b];
      end
      m_press   <= nxt[W] & ~m_stable[W];
      m_release <= ~nxt[W] & m_stable[W];
      m_changed <= (nxt[W-1:0] != m_stable[W-1:0]);
      m_stable  <= nxt;
      hist.push_back({btn_in, sw_in});
      void'(hist.pop_front());
    end
  end

  always @(negedge clock) begin
    logic [W+3:0] exp_v, act_v;
    #2;
    exp_v = {m_stable[W-1:0], m_stable[W], m_press, m_release, m_changed};
    act_v = {sw_out, btn_level, btn_press, btn_release, sw_changed};
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t: got %h expected %h", $time, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int npress, nrel, nchg, nhigh;
    logic [W-1:0] sw_or;

    // 1 reset with inputs high
    rst = 1'b0; sw_in = 4'hF; btn_in = 1'b1;
    repeat (3) cyc();
    chk("reset_outputs",
        {sw_out, btn_level, btn_press, btn_release, sw_changed}, 0);
    rst = 1'b1;
    npress = 0; nchg = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      npress += btn_press; nchg += sw_changed;
      if (k == 5) chk("rel_c5_sw", sw_out, 4'h0);
      if (k == 5) chk("rel_c5_btn", btn_level, 0);
      if (k == 6) begin
        chk("rel_c6_sw", sw_out, 4'hF);
        chk("rel_c6_btn", btn_level, 1);
        chk("rel_c6_press", btn_press, 1);
        chk("rel_c6_chg", sw_changed, 1);
      end
    end
    chk("rel_press_count", npress, 1);
    chk("rel_chg_count", nchg, 1);

    // 2 clean change 0 -> 5
    sw_in = 4'h0;
    repeat (10) cyc();
    sw_in = 4'h5; nchg = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      nchg += sw_changed;
      if (k == 5) chk("clean_c5", sw_out, 4'h0);
      if (k == 6) chk("clean_c6", sw_out, 4'h5);
      if (k == 6) chk("clean_c6_chg", sw_changed, 1);
    end
    chk("clean_chg_count", nchg, 1);

    // 3 button bounce
    btn_in = 1'b0;
    repeat (10) cyc();
    npress = 0; nhigh = 0;
    for (int t = 0; t < 30; t++) begin
      if (t % 3 == 0) btn_in = ~btn_in;
      cyc();
      nhigh += btn_level; npress += btn_press;
    end
    chk("bounce_level_low", nhigh, 0);
    btn_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      npress += btn_press;
      if (k == 5) chk("bounce_c5", btn_level, 0);
      if (k == 6) chk("bounce_c6", btn_level, 1);
      if (k == 6) chk("bounce_c6_press", btn_press, 1);
    end
    chk("bounce_press_count", npress, 1);

    // 4 glitch of D-1 clocks rejected, 5-clock pulse accepted
    sw_in = 4'h0;
    repeat (10) cyc();
    nchg = 0; sw_or = '0;
    sw_in = 4'h4;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) sw_in = 4'h0;
      cyc();
      nchg += sw_changed; sw_or |= sw_out;
    end
    chk("glitch_chg_count", nchg, 0);
    chk("glitch_sw_or", sw_or, 4'h0);
    sw_in = 4'h4;
    repeat (5) cyc();
    sw_in = 4'h0;
    cyc();
    chk("pulse5_sw", sw_out, 4'h4);
    chk("pulse5_chg", sw_changed, 1);
    repeat (10) cyc();
    chk("pulse5_back", sw_out, 4'h0);

    // 5 multi-bit change in one clock
    sw_in = 4'hA; nchg = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      nchg += sw_changed;
      if (k == 5) chk("multi_c5", sw_out, 4'h0);
      if (k == 6) chk("multi_c6", sw_out, 4'hA);
    end
    chk("multi_chg_count", nchg, 1);

    // 6 release, then reset during a pending change
    btn_in = 1'b0; nrel = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      nrel += btn_release;
      if (k == 5) chk("release_c5", btn_level, 1);
      if (k == 6) chk("release_c6", btn_level, 0);
      if (k == 6) chk("release_c6_pulse", btn_release, 1);
    end
    chk("release_count", nrel, 1);
    sw_in = 4'hF;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("midrst_outputs",
        {sw_out, btn_level, btn_press, btn_release, sw_changed}, 0);
    repeat (2) cyc();
    rst = 1'b1; nchg = 0; npress = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      nchg += sw_changed; npress += btn_press;
      if (k == 5) chk("midrst_c5", sw_out, 4'h0);
      if (k == 6) chk("midrst_c6", sw_out, 4'hF);
      if (k == 6) chk("midrst_c6_chg", sw_changed, 1);
    end
    chk("midrst_chg_count", nchg, 1);
    chk("midrst_press_count", npress, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
